// File: rtl/mips32_mem_arbiter_if.sv
// Bundle of the fetch port, data port and single-port memory bus shared
// by the MIPS32 memory arbiter. "slave" is the arbiter's view; "master"
// is the combined view of the two requesters plus the memory.
interface mips32_mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          halt;

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  halt, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output halt, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// Arbiter sharing one single-port synchronous word memory between the
// instruction-fetch port and the data-memory port. Data has priority,
// except that a fetch denied MAX_WAIT cycles in a row wins the next
// contest. Read data returns one cycle after the grant.
module mips32_mem_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  mips32_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  logic [3:0]    starve_q, starve_d;
  owner_e        rd_owner_q, rd_owner_d;

  logic          fetch_ok;
  logic          if_gnt;
  logic          dm_gnt;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  // Grant decision: data first unless fetch has starved long enough.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves a value unassigned and no latch is inferred.
    if_gnt   = 1'b0;
    dm_gnt   = 1'b0;
    fetch_ok = bus.if_req & ~bus.halt;
    if (!rst) begin
      if (bus.dm_req && fetch_ok && (starve_q == MAX_CNT)) begin
        if_gnt = 1'b1;
      end else if (bus.dm_req) begin
        dm_gnt = 1'b1;
      end else if (fetch_ok) begin
        if_gnt = 1'b1;
      end
    end
  end

  // Memory bus mux: the granted port drives the memory, idle drives zeros.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_addr = bus.if_addr;
    end else if (dm_gnt) begin
      mem_we    = bus.dm_we;
      mem_addr  = bus.dm_addr;
      mem_wdata = bus.dm_wdata;
    end
  end

  // Next state: starvation counter and owner of next cycle's read data.
  always_comb begin
    starve_d   = starve_q;
    rd_owner_d = OWN_NONE;
    if (if_gnt || !bus.if_req || bus.halt) begin
      starve_d = '0;
    end else if (starve_q != MAX_CNT) begin
      starve_d = starve_q + 4'd1;
    end
    if (if_gnt) begin
      rd_owner_d = OWN_IF;
    end else if (dm_gnt && !bus.dm_we) begin
      rd_owner_d = OWN_DM;
    end
  end

  // State registers; reset drops any in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q   <= '0;
      rd_owner_q <= OWN_NONE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      starve_q   <= starve_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.dm_gnt    = dm_gnt;
  assign bus.mem_en    = if_gnt | dm_gnt;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

  // Read return: one-cycle pulse, data passed through only to its owner.
  assign bus.if_rvalid = (rd_owner_q == OWN_IF);
  assign bus.dm_rvalid = (rd_owner_q == OWN_DM);
  assign bus.if_rdata  = (rd_owner_q == OWN_IF) ? bus.mem_rdata : '0;
  assign bus.dm_rdata  = (rd_owner_q == OWN_DM) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Self-checking bench for mips32_mem_arbiter: a behavioural memory, a
// reference model built from the arbitration rules, directed scenarios
// and a randomized phase.
module tb_mips32_mem_arbiter;
  localparam int AW       = 10;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips32_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mips32_mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Single-port synchronous memory with a preload side door.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    else if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Reference model state.
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            waits;
  bit            pend_if, pend_dm;
  logic [DW-1:0] pend_data;
  bit            last_if, last_dm;
  bit            prev_if_req;
  logic [AW-1:0] prev_if_addr;
  int            total = 0;
  int            bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already driven; check at the falling edge,
  // advance the model, then move to just after the next rising edge.
  task automatic cycle();
    bit            fok, eif, edm, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    @(negedge clk);
    if (rst) begin
      pend_if = 1'b0;
      pend_dm = 1'b0;
    end
    // Requester contract: an ungranted fetch keeps its address.
    assert (!(prev_if_req && !last_if && bus.if_req) || bus.if_addr == prev_if_addr) else begin
      bad++;
      $error("FAIL if_addr_changed observed=%0h expected=%0h", bus.if_addr, prev_if_addr);
    end
    fok = bus.if_req && !bus.halt;
    eif = 1'b0;
    edm = 1'b0;
    if (!rst) begin
      if (bus.dm_req && !(fok && waits >= MAX_WAIT)) edm = 1'b1;
      else if (fok) eif = 1'b1;
    end
    ea  = eif ? bus.if_addr : (edm ? bus.dm_addr : '0);
    ewe = edm && bus.dm_we;
    ewd = edm ? bus.dm_wdata : '0;
    check("if_gnt",    bus.if_gnt,    eif);
    check("dm_gnt",    bus.dm_gnt,    edm);
    check("mem_en",    bus.mem_en,    eif | edm);
    check("mem_we",    bus.mem_we,    ewe);
    check("mem_addr",  bus.mem_addr,  ea);
    check("mem_wdata", bus.mem_wdata, ewd);
    check("if_rvalid", bus.if_rvalid, pend_if);
    check("dm_rvalid", bus.dm_rvalid, pend_dm);
    check("if_rdata",  bus.if_rdata,  pend_if ? pend_data : '0);
    check("dm_rdata",  bus.dm_rdata,  pend_dm ? pend_data : '0);
    check("one_valid", bus.if_rvalid & bus.dm_rvalid, 1'b0);
    // Advance the model.
    pend_if = eif;
    pend_dm = edm && !bus.dm_we;
    if (eif) pend_data = shadow[bus.if_addr];
    if (edm && !bus.dm_we) pend_data = shadow[bus.dm_addr];
    if (edm && bus.dm_we) shadow[bus.dm_addr] = bus.dm_wdata;
    if (rst || !fok || eif) waits = 0;
    else if (waits < MAX_WAIT) waits++;
    last_if      = eif;
    last_dm      = edm;
    prev_if_req  = bus.if_req && !rst;
    prev_if_addr = bus.if_addr;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_we   = 1'b1;
    pl_addr = a;
    pl_data = d;
    shadow[a] = d;
    cycle();
    pl_we = 1'b0;
  endtask

  initial begin
    bus.halt     = 1'b0;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    waits = 0; pend_if = 0; pend_dm = 0; pend_data = '0;
    last_if = 0; last_dm = 0; prev_if_req = 0; prev_if_addr = '0;

    // Reset state.
    rst = 1'b1;
    bus.if_req = 1'b1;
    bus.dm_req = 1'b1;
    cycle();
    cycle();
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    rst = 1'b0;
    cycle();

    for (int i = 0; i < 16; i++) preload(AW'(i), DW'($urandom));
    preload(10'd0,   32'h2801_0078);
    preload(10'd2,   32'h2022_0000);
    preload(10'd120, 32'd85);

    // 1. Fetch only.
    bus.if_req = 1'b1; bus.if_addr = 10'd0;
    cycle();
    bus.if_req = 1'b0;
    cycle();

    // 2. Store then load of the same word.
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 10'd121; bus.dm_wdata = 32'd130;
    cycle();
    bus.dm_we = 1'b0;
    cycle();
    bus.dm_req = 1'b0;
    cycle();

    // 3. Continuous contention.
    bus.if_req = 1'b1; bus.if_addr = 10'd2;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 10'd120;
    repeat (9) cycle();
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    cycle();

    // 4. Halt blocks fetch grants; loads still served.
    bus.halt = 1'b1; bus.if_req = 1'b1; bus.if_addr = 10'd0;
    for (int i = 0; i < 6; i++) begin
      bus.dm_req = (i % 2 == 0);
      cycle();
    end
    bus.halt = 1'b0; bus.dm_req = 1'b0;
    cycle();
    bus.halt = 1'b1;
    cycle();
    bus.halt = 1'b0; bus.if_req = 1'b0;
    cycle();

    // 5. Reset while a fetch read is in flight.
    bus.if_req = 1'b1; bus.if_addr = 10'd0;
    cycle();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    bus.if_req = 1'b0;
    cycle();

    // 6. Alternating owners on consecutive cycles.
    bus.if_req = 1'b1; bus.if_addr = 10'd2;
    cycle();
    bus.if_req = 1'b0; bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 10'd120;
    cycle();
    bus.dm_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 10'd2;
    cycle();
    bus.if_req = 1'b0;
    cycle();
    cycle();

    // Randomized traffic honouring the requester contract.
    for (int n = 0; n < 500; n++) begin
      if (!bus.if_req || last_if) begin
        bus.if_req  = ($urandom_range(0, 3) != 0);
        bus.if_addr = AW'($urandom_range(0, 15));
      end else if ($urandom_range(0, 7) == 0) begin
        bus.if_req = 1'b0;
      end
      if (!bus.dm_req || last_dm) begin
        bus.dm_req   = ($urandom_range(0, 2) != 0);
        bus.dm_we    = ($urandom_range(0, 2) == 0);
        bus.dm_addr  = AW'($urandom_range(0, 15));
        bus.dm_wdata = DW'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        bus.dm_req = 1'b0;
      end
      bus.halt = ($urandom_range(0, 9) == 0);
      rst      = ($urandom_range(0, 79) == 0);
      cycle();
    end
    rst = 1'b0;
    bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.halt = 1'b0;
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips32_mem_arbiter.md
Name: mips32_mem_arbiter

Overview:
- Shares one single-port synchronous word memory between the MIPS32 instruction-fetch port (IF) and the data-memory port (MEM stage load/store).
- At most one access is issued per cycle.
- The data port has fixed priority, bounded by an anti-starvation counter that guarantees fetch progress.
- A halt input blocks new fetch grants once HLT has retired, matching the processor's HALTED behaviour.

Parameters:
AW, 10, word address width (memory depth 2**AW words)
DW, 32, data word width
MAX_WAIT, 3, consecutive denied fetch cycles after which fetch beats data (1..15)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
halt  in  1  processor halted; suppresses fetch grants
if_req  in  1  fetch request; held with if_addr stable until if_gnt
if_addr  in  AW  fetch word address
if_gnt  out  1  fetch accepted this cycle (combinational)
if_rvalid  out  1  fetch read data valid (registered pulse)
if_rdata  out  DW  fetch read data
dm_req  in  1  data request; held with dm_we/addr/wdata stable until dm_gnt
dm_we  in  1  1 = store, 0 = load
dm_addr  in  AW  data word address
dm_wdata  in  DW  store data
dm_gnt  out  1  data access accepted this cycle (combinational)
dm_rvalid  out  1  load data valid (registered pulse)
dm_rdata  out  DW  load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid one cycle after mem_en with mem_we=0

Behaviour:
- Reset (async, rst=1): starve_cnt=0, rd_owner=NONE, if_rvalid=0, dm_rvalid=0. if_gnt, dm_gnt, mem_en and mem_we are forced to 0 while rst=1.
- Grant decision, combinational each cycle:
  - fetch_ok = if_req & ~halt.
  - dm_req & fetch_ok & (starve_cnt == MAX_WAIT) -> IF granted.
  - otherwise dm_req -> DM granted.
  - otherwise fetch_ok -> IF granted.
  - otherwise idle.
- Exactly one of if_gnt/dm_gnt is high, or neither. mem_en = if_gnt | dm_gnt.
- Memory mux:
  - IF grant: mem_addr = if_addr, mem_we = 0.
  - DM grant: mem_addr = dm_addr, mem_we = dm_we, mem_wdata = dm_wdata.
  - Idle: mem_addr, mem_we and mem_wdata are 0.
- starve_cnt (4-bit), updated on posedge:
  - cleared when if_gnt, ~if_req, or halt.
  - incremented when if_req & ~halt & ~if_gnt, saturating at MAX_WAIT.
- Read ownership register rd_owner ∈ {NONE, IF, DM}:
  - set to IF on an IF grant, to DM on a DM load grant.
  - NONE on a store grant or idle.
- Read return, latency 1:
  - if_rvalid <= (next rd_owner == IF); dm_rvalid <= (next rd_owner == DM). Both are single-cycle pulses per granted load or fetch.
  - Rdata is combinational pass-through of mem_rdata, qualified by rd_owner. The unselected rdata output is held at 0.
- Stores produce no rvalid. A store followed by a load to the same address on the next cycle returns the new data (the memory is write-first by sequencing; no bypass is needed in the arbiter).
- Back-to-back grants to alternating owners are legal every cycle. Returns follow grant order one cycle later, with no gaps.
- halt asserted while a fetch read is in flight: that fetch's if_rvalid still issues next cycle. Only new grants are blocked.
- Reset mid-operation: an in-flight read is dropped, no rvalid is issued after reset deasserts, and the counter restarts at 0.
- Requester contract: deasserting req before gnt is legal, and the request is simply abandoned. Changing the address while req is high and ungranted is illegal. The bench flags it with an assertion.

Test Plan:
1. Fetch only: mem[0]=0x28010078, if_req=1, if_addr=0 -> if_gnt=1 same cycle, mem_en=1 mem_we=0; next cycle if_rvalid=1, if_rdata=0x28010078, dm_rvalid=0.
2. Store/load: dm_we=1 addr=121 wdata=130 -> dm_gnt=1, mem_we=1, no dm_rvalid. Next cycle load addr=121 -> following cycle dm_rvalid=1, dm_rdata=130.
3. Contention, MAX_WAIT=3: if_req and dm_req held high continuously -> grant sequence DM,DM,DM,IF repeating. starve_cnt reads 0,1,2,3,0. Every if_rvalid/dm_rvalid lands one cycle after its grant.
4. Halt: halt=1, if_req=1, dm_req pulsed -> if_gnt never asserts, dm loads still served, starve_cnt stays 0. Drop halt -> if_gnt in the first cycle without dm_req.
5. Reset mid-read: IF grant at cycle N, rst=1 during cycle N+1 -> if_rvalid=0 after release, all grants 0 during reset, first post-reset grant behaves as in scenario 1.
6. Alternating ownership: mem[120]=85, mem[2]=0x20220000; IF@2, DM load@120, IF@2 on consecutive cycles (data not competing) -> if_rvalid/0x20220000, dm_rvalid/85, if_rvalid/0x20220000 on consecutive cycles, never both valid together.
